// File: rtl/pipeline_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the processor's imem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_imem_loader_pkg;

    // Loader FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERR    = 3'd4
    } loader_state_t;

    // Instruction memory geometry shared with pipeline_processor
    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_DEPTH  = 256;

    // Cycles the processor is held in reset after the final write
    localparam int LOADER_SETTLE_CYCLES = 4;

endpackage

// File: rtl/pipeline_imem_loader_settle_counter.sv
// Down-counter timing the post-load settle interval; o_zero flags expiry.
// Latency: load takes effect next cycle; o_zero is a pure decode of the count.
// Backpressure: none; i_load wins over i_dec, the count holds at zero.
module loader_settle_counter #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Load SETTLE_CYCLES-1 on entry, count down while settling, stop at zero
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipeline_imem_loader.sv
// Streams a program into instruction memory from address 0, then releases cpu reset after a settle interval.
// Latency: memory write 1 cycle after each handshake; cpu_reset drops SETTLE_CYCLES cycles after the last write.
// Backpressure: s_ready is high only while loading; the stream stalls in every other state.
module pipeline_imem_loader
    import pipeline_imem_loader_pkg::*;
#(
    parameter int ADDR_W        = IMEM_ADDR_W,
    parameter int DATA_W        = IMEM_DATA_W,
    parameter int DEPTH         = IMEM_DEPTH,
    parameter int SETTLE_CYCLES = LOADER_SETTLE_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_last,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_cpu_reset,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_word_count
);

    // Highest legal address; the counter stops here instead of wrapping
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_s_ready;
    logic w_cpu_reset;
    logic w_done;
    logic w_error;
    logic w_clear;
    logic w_hs;
    logic w_at_last_addr;
    logic w_settle_zero;

    assign w_hs           = w_s_ready & i_s_valid;
    assign w_at_last_addr = (r_addr == LAST_ADDR);

    loader_settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_hs & i_s_last),
        .i_dec   (r_state == ST_SETTLE),
        .o_zero  (w_settle_zero)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded control outputs
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_s_ready    = 1'b0;
        w_cpu_reset  = 1'b1;
        w_done       = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_LOAD;
                    w_clear      = 1'b1;
                end
            end
            ST_LOAD: begin
                w_s_ready = 1'b1;
                if (w_hs) begin
                    if (i_s_last) begin
                        w_next_state = ST_SETTLE;
                    end else if (w_at_last_addr) begin
                        w_next_state = ST_ERR;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_settle_zero) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cpu_reset = 1'b0;
                w_done      = 1'b1;
                if (i_start) begin
                    w_next_state = ST_LOAD;
                    w_clear      = 1'b1;
                end
            end
            ST_ERR: begin
                w_error = 1'b1;
                if (i_start) begin
                    w_next_state = ST_LOAD;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Write register, address counter and saturating word count
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_addr       <= '0;
            r_word_count <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= w_hs;
            if (w_hs) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= i_s_data;
            end
            if (w_clear) begin
                r_addr       <= '0;
                r_word_count <= '0;
            end else if (w_hs) begin
                if (!w_at_last_addr) begin
                    r_addr <= r_addr + ADDR_ONE;
                end
                if (r_word_count != CNT_MAX) begin
                    r_word_count <= r_word_count + CNT_ONE;
                end
            end
        end
    end

    assign o_s_ready    = w_s_ready;
    assign o_cpu_reset  = w_cpu_reset;
    assign o_done       = w_done;
    assign o_error      = w_error;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_pipeline_imem_loader.sv
// Bench for pipeline_imem_loader with a small memory (DEPTH fills the whole address space).
// Directed load/backpressure/overflow/reload/reset scenarios, then random traffic.
// Every cycle the outputs are compared against a phase-level reference model.
module tb_pipeline_imem_loader;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 4;

    localparam int P_IDLE = 0, P_LOAD = 1, P_SETTLE = 2, P_RUN = 3, P_ERR = 4;

    logic              clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_start = 1'b0;
    logic              i_s_valid = 1'b0;
    logic [DATA_W-1:0] i_s_data = '0;
    logic              i_s_last = 1'b0;
    logic              o_s_ready, o_mem_we, o_cpu_reset, o_done, o_error;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [ADDR_W:0]   o_word_count;

    pipeline_imem_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
        .i_s_last(i_s_last), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_cpu_reset(o_cpu_reset), .o_done(o_done),
        .o_error(o_error), .o_word_count(o_word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: current phase plus the expected registered outputs
    int          m_phase = P_IDLE;
    int          m_addr  = 0;
    int          m_cnt   = 0;
    int          m_left  = 0;
    bit          e_we    = 1'b0;
    int          e_addr  = 0;
    logic [31:0] e_data  = '0;

    // Every write seen on the memory port, as {addr, data}
    logic [63:0] wlog[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge given the inputs present at that edge
    task automatic model_update(input bit st, input bit v, input bit l, input bit r,
                                input logic [31:0] d);
        bit hs;
        hs = r && (m_phase == P_LOAD) && v;
        if (!r) begin
            m_phase = P_IDLE; m_addr = 0; m_cnt = 0; m_left = 0;
            e_we = 1'b0; e_addr = 0; e_data = '0;
        end else begin
            e_we = hs;
            if (hs) begin
                e_addr = m_addr;
                e_data = d;
                if (m_cnt < DEPTH) m_cnt++;
            end
            case (m_phase)
                P_LOAD: begin
                    if (hs) begin
                        if (l) begin
                            m_phase = P_SETTLE;
                            m_left  = SETTLE;
                        end else if (m_addr == DEPTH - 1) begin
                            m_phase = P_ERR;
                        end else begin
                            m_addr++;
                        end
                    end
                end
                P_SETTLE: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_RUN;
                end
                default: begin
                    if (st) begin
                        m_phase = P_LOAD; m_addr = 0; m_cnt = 0;
                    end
                end
            endcase
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready",    64'(o_s_ready),    64'(m_phase == P_LOAD));
            chk("cpu_reset",  64'(o_cpu_reset),  64'(m_phase != P_RUN));
            chk("done",       64'(o_done),       64'(m_phase == P_RUN));
            chk("error",      64'(o_error),      64'(m_phase == P_ERR));
            chk("mem_we",     64'(o_mem_we),     64'(e_we));
            chk("word_count", 64'(o_word_count), 64'(m_cnt));
            if (e_we) begin
                chk("mem_addr",  64'(o_mem_addr),  64'(e_addr));
                chk("mem_wdata", 64'(o_mem_wdata), 64'(e_data));
            end
        end
        if (o_mem_we === 1'b1) wlog.push_back({30'd0, o_mem_addr, o_mem_wdata});
    end

    task automatic step(input bit st, input bit v, input bit l, input bit r,
                        input logic [31:0] d);
        i_start = st; i_s_valid = v; i_s_last = l; i_reset = r; i_s_data = d;
        @(posedge clk);
        model_update(st, v, l, r, d);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic wait_run(input string nm);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 20) begin
            idle();
            n++;
        end
        chk(nm, 64'(o_done), 64'd1);
    endtask

    task automatic chk_log(input string nm, input int idx, input int addr, input logic [31:0] data);
        if (idx < wlog.size()) chk(nm, wlog[idx], {30'd0, 2'(addr), data});
        else chk({nm, "_missing"}, 64'(wlog.size()), 64'(idx + 1));
    endtask

    logic [31:0] prog[3];

    initial begin
        int settle_n;
        int vpat[6];
        prog[0] = 32'h00000013; prog[1] = 32'h00A00093; prog[2] = 32'h00108113;

        // Reset for two cycles, start in cycle 2, three back-to-back words
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_cpu_reset", 64'(o_cpu_reset), 64'd1);
        chk("rst_s_ready",   64'(o_s_ready),   64'd0);
        chk("rst_count",     64'(o_word_count), 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        wlog.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, (i == 2), 1'b1, prog[i]);
        // Now in the cycle carrying the last write; count cycles still in reset
        settle_n = 0;
        while (o_cpu_reset === 1'b1 && settle_n < 20) begin
            settle_n++;
            idle();
        end
        chk("t1_settle_cycles", 64'(settle_n), 64'd4);
        chk("t1_done", 64'(o_done), 64'd1);
        chk("t1_count", 64'(o_word_count), 64'd3);
        chk("t1_nwrites", 64'(wlog.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk_log("t1_write", i, i, prog[i]);

        // Backpressure gaps: valid 1,0,0,1,0,1 with last on the third word
        vpat = '{1, 0, 0, 1, 0, 1};
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        wlog.delete();
        for (int i = 0; i < 6; i++)
            step(1'b0, vpat[i] != 0, (i == 5), 1'b1, 32'hB000_0000 + 32'(i));
        wait_run("t2_run");
        chk("t2_nwrites", 64'(wlog.size()), 64'd3);
        chk_log("t2_w0", 0, 0, 32'hB000_0000);
        chk_log("t2_w1", 1, 1, 32'hB000_0003);
        chk_log("t2_w2", 2, 2, 32'hB000_0005);

        // Overflow: DEPTH words without last
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        wlog.delete();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'hC000_0000 + 32'(i));
        chk("t3_error", 64'(o_error), 64'd1);
        chk("t3_s_ready", 64'(o_s_ready), 64'd0);
        idle(); idle();
        chk("t3_cpu_reset", 64'(o_cpu_reset), 64'd1);
        chk("t3_nwrites", 64'(wlog.size()), 64'd4);
        for (int i = 0; i < DEPTH; i++) chk_log("t3_write", i, i, 32'hC000_0000 + 32'(i));
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("t3_recover_error", 64'(o_error), 64'd0);
        chk("t3_recover_ready", 64'(o_s_ready), 64'd1);

        // Exact fit: DEPTH words with last on the final one
        wlog.delete();
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, (i == DEPTH - 1), 1'b1, 32'hD000_0000 + 32'(i));
        chk("t4_no_error", 64'(o_error), 64'd0);
        wait_run("t4_run");
        chk("t4_count", 64'(o_word_count), 64'd4);
        chk_log("t4_last", 3, 3, 32'hD000_0003);

        // Reload from RUN with a two-word program
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("t5_cpu_reset", 64'(o_cpu_reset), 64'd1);
        chk("t5_done", 64'(o_done), 64'd0);
        wlog.delete();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hE000_0000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hE000_0001);
        wait_run("t5_run");
        chk("t5_count", 64'(o_word_count), 64'd2);
        chk_log("t5_w0", 0, 0, 32'hE000_0000);
        chk_log("t5_w1", 1, 1, 32'hE000_0001);

        // Reset in the middle of a load, then stream traffic that must be ignored
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        wlog.delete();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hF000_0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hF000_0001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hF000_0002);
        chk("t6_mem_we", 64'(o_mem_we), 64'd0);
        chk("t6_cpu_reset", 64'(o_cpu_reset), 64'd1);
        chk("t6_count", 64'(o_word_count), 64'd0);
        chk("t6_addr_data", {30'd0, o_mem_addr, o_mem_wdata}, 64'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'hF100_0000 + 32'(i));
        chk("t6_nwrites", 64'(wlog.size()), 64'd2);
        chk("t6_ready", 64'(o_s_ready), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(15) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
                 $urandom_range(80) != 0, $urandom);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_imem_loader.md
Name: pipeline_imem_loader

Overview:
Writer-side companion to pipeline_processor's instruction memory. Accepts a program as a valid/ready word stream, writes it sequentially into instruction memory from address 0, and holds the processor in reset until the load has completed and a settle interval has elapsed. It replaces the fixed reset pulse at the top level with a controlled load-then-run sequence. It supports reload without a global reset.

Parameters:
ADDR_W, 8, instruction memory address width (word addressed)
DATA_W, 32, instruction word width
DEPTH, 256, number of memory words (must be <= 2**ADDR_W)
SETTLE_CYCLES, 4, cycles cpu_reset stays high after the last write (>= 1)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse that begins a (re)load
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_data  in  DATA_W  instruction word
s_last  in  1  marks final word of program
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
cpu_reset  out  1  active-high reset to pipeline_processor
done  out  1  program loaded, processor running
error  out  1  overflow: DEPTH words accepted without s_last
word_count  out  ADDR_W+1  words written in the current or last load

Behaviour:
- Reset: clk edge with reset==0 clears all state. Resulting outputs: state IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, word_count=0. Reset asserted mid-load aborts the load; no further writes occur.
- FSM states: IDLE, LOAD, SETTLE, RUN, ERR. State is registered; s_ready, cpu_reset, done and error are decoded from state.
- IDLE:
  - cpu_reset=1, s_ready=0.
  - s_valid is ignored.
  - start -> LOAD. Address counter and word_count are cleared on entry.
- LOAD:
  - s_ready=1, cpu_reset=1.
  - Handshake = s_valid & s_ready in cycle k. In cycle k+1: mem_we=1, mem_addr=address, mem_wdata=s_data (registered, latency 1). mem_we is 0 in every cycle with no preceding handshake.
  - The address counter increments per handshake. word_count increments per write.
  - A handshake with s_last=1 -> SETTLE.
  - A handshake at address DEPTH-1 with s_last=0 -> ERR. That word is still written.
  - A handshake at address DEPTH-1 with s_last=1 is legal -> SETTLE.
  - start is ignored.
- SETTLE:
  - s_ready=0, cpu_reset=1.
  - A down-counter loaded with SETTLE_CYCLES-1 decrements each cycle; at 0 -> RUN.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles; the final mem write lands in the first SETTLE cycle.
  - start is ignored.
- RUN:
  - cpu_reset=0, done=1, s_ready=0.
  - start -> LOAD. In the next cycle cpu_reset=1, done=0, the address counter is cleared and word_count is cleared.
- ERR:
  - error=1, cpu_reset=1, s_ready=0, done=0.
  - Left only via reset (-> IDLE) or start (-> LOAD, error clears).
- Simultaneous events: reset overrides start and handshakes.
- Width rules: the address counter is ADDR_W bits and never wraps, because ERR is entered before any wrap. word_count saturates at DEPTH.

Decomposition:
- Shared package: FSM state encoding (loader_state_t, 3-bit), and the default ADDR_W, DATA_W and SETTLE_CYCLES constants shared with the processor's instruction memory.
- One sub-module is natural: loader_settle_counter (load/decrement/zero-flag down-counter).
- The FSM and write register stay in the top module.

Test Plan:
- Reset, then start at cycle 2, then 3 words 0x00000013, 0x00A00093, 0x00108113 (last on the third), s_valid held high. Required response:
  - Writes to addresses 0, 1, 2 with those data, one cycle after each handshake.
  - word_count=3.
  - cpu_reset falls exactly 4 cycles after the cycle of the last write's handshake + 1.
  - done=1.
- Backpressure gaps: s_valid toggled 1,0,0,1,0,1 with last on the third word -> exactly 3 mem_we pulses, at addresses 0, 1, 2. There are no writes in the gap cycles.
- Overflow with DEPTH=4 (override): 4 words, no s_last. Required response:
  - 4 writes to addresses 0-3.
  - error=1 the cycle after the 4th handshake.
  - s_ready=0 and cpu_reset stays 1.
  - start then recovers to LOAD with error=0.
- Exact fit with DEPTH=4: 4 words with s_last on the 4th -> no error, RUN reached, word_count=4.
- Reload from RUN: start pulse -> cpu_reset=1 and done=0 next cycle. A 2-word load rewrites addresses 0-1, and word_count=2.
- Reset mid-LOAD after 2 handshakes:
  - No further mem_we.
  - State returns to IDLE with outputs at reset values.
  - s_valid afterwards is ignored until start.
